// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: FSM states, access sizes,
// funct3 load/store codes and writeback-select codes.
package mem_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } access_size_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_LOAD  = 2'b01;
  localparam logic [1:0] WB_PC4   = 2'b10;
  localparam logic [1:0] WB_UTYPE = 2'b11;

  // The low two funct3 bits give the size; unused encodings fall back to word.
  function automatic access_size_t access_size(input logic [2:0] funct3);
    case (funct3[1:0])
      F3_SB[1:0]: return SZ_BYTE;
      F3_SH[1:0]: return SZ_HALF;
      default:    return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr_lo)
      2'b00:   byte_lane = rdata[7:0];
      2'b01:   byte_lane = rdata[15:8];
      2'b10:   byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
  end

  assign half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // Reserved encodings (011/110/111) behave like LW.
  always_comb begin
    case (funct3)
      F3_LB:   load_data = {{24{byte_lane[7]}}, byte_lane};
      F3_LH:   load_data = {{16{half_lane[15]}}, half_lane};
      F3_LBU:  load_data = {24'd0, byte_lane};
      F3_LHU:  load_data = {16'd0, half_lane};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: drives the data bus, stalls the pipeline while waiting for ack and
// registers the MEM/WB values. Define MEM_TIMEOUT_EN to abort hung accesses.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        reg_write_i,
  input  logic [1:0]  mem_to_reg_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rd2_i,
  input  logic [4:0]  wr_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] pc_plus_four_i,
  input  logic [31:0] utype_res_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        timeout_o,
  output logic        mem_wb_reg_write_o,
  output logic [4:0]  mem_wb_wr_o,
  output logic [31:0] mem_wb_result_o
);

  mem_state_t   state;
  access_size_t size;
  logic         mem_access;
  logic         misaligned;
  logic         pending;
  logic         is_load;
  logic         commit;
  logic         timeout_hit;
  logic [31:0]  load_data;
  logic [31:0]  wb_result;

  assign size       = access_size(funct3_i);
  assign mem_access = mem_read_i | mem_write_i;
  assign is_load    = mem_read_i & ~mem_write_i;

  always_comb begin
    case (size)
      SZ_HALF: misaligned = alu_result_i[0];
      SZ_WORD: misaligned = |alu_result_i[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign pending = mem_access & ~misaligned;

  // Bus fields come straight from the EX/MEM inputs, which the stall holds steady.
  assign dmem_req_o  = (state == ST_WAIT);
  assign dmem_we_o   = (state == ST_WAIT) & mem_write_i;
  assign dmem_addr_o = {alu_result_i[31:2], 2'b00};

  always_comb begin
    case (size)
      SZ_BYTE: begin
        dmem_be_o    = 4'b0001 << alu_result_i[1:0];
        dmem_wdata_o = {4{rd2_i[7:0]}};
      end
      SZ_HALF: begin
        dmem_be_o    = alu_result_i[1] ? 4'b1100 : 4'b0011;
        dmem_wdata_o = {2{rd2_i[15:0]}};
      end
      default: begin
        dmem_be_o    = 4'b1111;
        dmem_wdata_o = rd2_i;
      end
    endcase
  end

  load_align u_load_align (
    .rdata     (dmem_rdata_i),
    .addr_lo   (alu_result_i[1:0]),
    .funct3    (funct3_i),
    .load_data (load_data)
  );

  // Stores (including read+write together) have no load value to return.
  always_comb begin
    case (mem_to_reg_i)
      WB_ALU:  wb_result = alu_result_i;
      WB_LOAD: wb_result = is_load ? load_data : 32'd0;
      WB_PC4:  wb_result = pc_plus_four_i;
      default: wb_result = utype_res_i;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign timeout_hit = (state == ST_WAIT) && !dmem_ack_i &&
                       (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == ST_IDLE) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // The final timeout cycle drops the stall so the abandoned access leaves EX/MEM.
  assign stall_o = ((state == ST_IDLE) && pending) ||
                   ((state == ST_WAIT) && !dmem_ack_i && !timeout_hit);

  assign commit = ((state == ST_IDLE) && !mem_access) ||
                  ((state == ST_WAIT) && dmem_ack_i);

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      misalign_o         <= 1'b0;
      timeout_o          <= 1'b0;
      mem_wb_reg_write_o <= 1'b0;
      mem_wb_wr_o        <= '0;
      mem_wb_result_o    <= '0;
    end else begin
      misalign_o         <= (state == ST_IDLE) && mem_access && misaligned;
      timeout_o          <= timeout_hit;
      mem_wb_reg_write_o <= commit & reg_write_i;
      mem_wb_wr_o        <= commit ? wr_i : 5'd0;
      mem_wb_result_o    <= commit ? wb_result : 32'd0;
      case (state)
        ST_IDLE: if (pending) state <= ST_WAIT;
        ST_WAIT: if (dmem_ack_i || timeout_hit) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transaction-level model predicts every
// output each cycle, plus literal pins for the key load/store/misalign cases.
module tb_mem_access_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write, reg_write, ack;
  logic [1:0]  m2r;
  logic [31:0] alu, rd2, pc4, ut, rdata;
  logic [4:0]  wr;
  logic [2:0]  f3;

  logic        dmem_req, dmem_we, stall, misalign, timeout, wb_we;
  logic [31:0] dmem_addr, dmem_wdata, wb_result;
  logic [3:0]  dmem_be;
  logic [4:0]  wb_wr;

  int checks = 0;
  int errors = 0;
  int stall_seen = 0;
  bit check_en = 1'b0;

  logic        exp_stall, exp_req, exp_we, exp_misalign, exp_timeout, exp_wb_we;
  logic [31:0] exp_addr, exp_wdata, exp_wb_result;
  logic [3:0]  exp_be;
  logic [4:0]  exp_wb_wr;
  logic [3:0]  seen_be;
  logic [31:0] seen_wdata;
  logic        seen_we;

  mem_access_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_i(mem_read), .mem_write_i(mem_write), .reg_write_i(reg_write),
    .mem_to_reg_i(m2r), .alu_result_i(alu), .rd2_i(rd2), .wr_i(wr), .funct3_i(f3),
    .pc_plus_four_i(pc4), .utype_res_i(ut),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
    .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata),
    .dmem_ack_i(ack), .dmem_rdata_i(rdata),
    .stall_o(stall), .misalign_o(misalign), .timeout_o(timeout),
    .mem_wb_reg_write_o(wb_we), .mem_wb_wr_o(wb_wr), .mem_wb_result_o(wb_result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int size_bytes(input logic [2:0] fn);
    if (fn[1:0] == 2'b00) return 1;
    if (fn[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] fn, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] v;
    v = w >> (8 * a);
    case (fn)
      3'b000: begin v = v & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
      3'b100:       v = v & 32'hFF;
      3'b001: begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
      3'b101:       v = v & 32'hFFFF;
      default:      v = w;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] fn, input logic [1:0] a);
    case (size_bytes(fn))
      1:       return 4'(1 << a);
      2:       return (a >= 2'd2) ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] fn, input logic [31:0] d);
    case (size_bytes(fn))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  task automatic setWb(input logic we, input logic [4:0] w, input logic [31:0] r);
    exp_wb_we = we;
    exp_wb_wr = w;
    exp_wb_result = r;
  endtask

  // One instruction through MEM; ack_after = WAIT cycle carrying ack, -1 = never.
  task automatic applyStimulus(input logic rd, input logic wrt, input logic rw,
                               input logic [1:0] mtr, input logic [2:0] fn,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [4:0] w, input logic [31:0] rdat,
                               input int ack_after);
    bit is_mem, mis, done, tmo;
    logic [31:0] res;
    is_mem = rd | wrt;
    mis = is_mem && ((a % size_bytes(fn)) != 0);
    case (mtr)
      2'b00:   res = a;
      2'b01:   res = (rd && !wrt) ? model_load(fn, a[1:0], rdat) : 32'd0;
      2'b10:   res = pc4;
      default: res = ut;
    endcase
    @(posedge clk);
    mem_read = rd; mem_write = wrt; reg_write = rw; m2r = mtr; f3 = fn;
    alu = a; rd2 = d; wr = w; ack = 1'b0; rdata = $urandom;
    exp_stall = is_mem && !mis;
    exp_req = 1'b0;
    @(negedge clk); #1;
    exp_misalign = mis;
    exp_timeout = 1'b0;
    if (!is_mem) setWb(rw, w, res);
    else setWb(1'b0, 5'd0, 32'd0);
    if (is_mem && !mis) begin
      for (int c = 1; c <= 64; c++) begin
        @(posedge clk);
        done = (c == ack_after);
        tmo = (ack_after < 0) && (c == TIMEOUT);
        ack = done;
        rdata = done ? rdat : $urandom;
        exp_req = 1'b1;
        exp_we = wrt;
        exp_addr = a & ~32'd3;
        exp_be = model_be(fn, a[1:0]);
        exp_wdata = model_wdata(fn, d);
        exp_stall = !done && !tmo;
        @(negedge clk); #1;
        exp_misalign = 1'b0;
        exp_timeout = tmo;
        if (done) setWb(rw, w, res);
        else setWb(1'b0, 5'd0, 32'd0);
        if (done || tmo) break;
      end
    end
  endtask

  // Reset lands in the second WAIT cycle together with ack; the ack data must be lost.
  task automatic resetDuringWait();
    @(posedge clk);
    mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1; m2r = 2'b01; f3 = 3'b010;
    alu = 32'h0000_0104; wr = 5'd9; ack = 1'b0;
    exp_stall = 1'b1; exp_req = 1'b0;
    @(negedge clk); #1;
    exp_misalign = 1'b0; exp_timeout = 1'b0; setWb(1'b0, 5'd0, 32'd0);
    @(posedge clk);
    exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h0000_0104; exp_be = 4'hF;
    exp_wdata = rd2; exp_stall = 1'b1;
    @(negedge clk); #1;
    @(posedge clk);
    rst_n = 1'b0; ack = 1'b1; rdata = 32'h5555_AAAA;
    exp_stall = 1'b0;
    @(negedge clk); #1;
    setWb(1'b0, 5'd0, 32'd0);
    @(posedge clk);
    rst_n = 1'b1; ack = 1'b0;
    mem_read = 1'b0; reg_write = 1'b0; m2r = 2'b00; alu = 32'd0; wr = 5'd0;
    exp_req = 1'b0; exp_stall = 1'b0;
    @(negedge clk); #1;
  endtask

  // Single compare process: every cycle, away from the falling active edge.
  always @(posedge clk) begin
    #2;
    if (check_en) begin
      if (stall === 1'b1) stall_seen++;
      checkOutput("stall", stall, exp_stall);
      checkOutput("dmem_req", dmem_req, exp_req);
      if (exp_req) begin
        checkOutput("dmem_we", dmem_we, exp_we);
        checkOutput("dmem_addr", dmem_addr, exp_addr);
        checkOutput("dmem_be", dmem_be, exp_be);
        checkOutput("dmem_wdata", dmem_wdata, exp_wdata);
        seen_be = dmem_be;
        seen_wdata = dmem_wdata;
        seen_we = dmem_we;
      end
      checkOutput("misalign", misalign, exp_misalign);
      checkOutput("timeout", timeout, exp_timeout);
      checkOutput("wb_reg_write", wb_we, exp_wb_we);
      checkOutput("wb_wr", wb_wr, exp_wb_wr);
      checkOutput("wb_result", wb_result, exp_wb_result);
    end
  end

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; m2r = 2'b00;
    alu = '0; rd2 = '0; wr = '0; f3 = '0; ack = 1'b0; rdata = '0;
    pc4 = 32'h0000_2004; ut = 32'h1234_5000;
    exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_be = '0;
    exp_wdata = '0; exp_misalign = 1'b0; exp_timeout = 1'b0; setWb(1'b0, 5'd0, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check_en = 1'b1;
    @(negedge clk); #1;
    rst_n = 1'b1;

    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 32'h1234_5678, 32'd0, 5'd5, 32'd0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b10, 3'b000, 32'h0000_0010, 32'd0, 5'd1, 32'd0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b11, 3'b000, 32'h0000_0020, 32'd0, 5'd7, 32'd0, 0);

    stall_seen = 0;
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 3'b000, 32'h0000_0103, 32'd0, 5'd10, 32'h80FF_FF7F, 3);
    checkOutput("lb_stall_cycles_pin", stall_seen, 32'd3);
    checkOutput("lb_result_pin", wb_result, 32'hFFFF_FF80);
    checkOutput("lb_reg_write_pin", wb_we, 32'd1);

    applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 3'b100, 32'h0000_0101, 32'd0, 5'd11, 32'h1234_5678, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 3'b001, 32'h0000_0102, 32'd0, 5'd12, 32'h8001_0000, 2);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 3'b101, 32'h0000_0100, 32'd0, 5'd13, 32'h0000_F00D, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 32'h0000_0104, 32'd0, 5'd14, 32'hDEAD_BEEF, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 3'b111, 32'h0000_0108, 32'd0, 5'd15, 32'hCAFE_F00D, 2);

    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 5'd0, 32'd0, 2);
    checkOutput("sh_be_pin", seen_be, 32'h0000_000C);
    checkOutput("sh_wdata_pin", seen_wdata, 32'hBEEF_BEEF);
    checkOutput("sh_we_pin", seen_we, 32'd1);
    checkOutput("sh_reg_write_pin", wb_we, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 32'h0000_0201, 32'h0000_00AB, 5'd0, 32'd0, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 3'b010, 32'h0000_0204, 32'h0102_0304, 5'd0, 32'd0, 1);

    stall_seen = 0;
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 32'h0000_0101, 32'd0, 5'd16, 32'd0, 1);
    checkOutput("lw_misalign_pin", misalign, 32'd1);
    checkOutput("lw_misalign_stall_pin", stall_seen, 32'd0);
    checkOutput("lw_misalign_reg_write_pin", wb_we, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 3'b001, 32'h0000_0203, 32'h0000_1111, 5'd0, 32'd0, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 32'h0000_0044, 32'd0, 5'd2, 32'd0, 0);

    applyStimulus(1'b1, 1'b1, 1'b1, 2'b01, 3'b010, 32'h0000_0300, 32'h1122_3344, 5'd17, 32'h7777_7777, 1);
    checkOutput("both_high_result_pin", wb_result, 32'd0);

    resetDuringWait();
    checkOutput("reset_req_pin", dmem_req, 32'd0);

`ifdef MEM_TIMEOUT_EN
    stall_seen = 0;
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 3'b010, 32'h0000_0400, 32'd0, 5'd18, 32'd0, -1);
    checkOutput("timeout_stall_cycles_pin", stall_seen, 32'd16);
    checkOutput("timeout_pulse_pin", timeout, 32'd1);
`endif

    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 32'h0000_0099, 32'd0, 5'd3, 32'd0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 32'd0, 32'd0, 5'd0, 32'd0, 0);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
